debug_hex_streamer: RTL and testbench

Serialises one parallel ASCII hex word into a byte stream for the debug UART. Sits directly downstream of the combinational nibble-to-ASCII encoder: it captures the encoder's `NBR_OF_NIBBLES*8`-bit output, then emits it one character at a time, most significant nibble first, followed by a line terminator. Both sides use valid/ready handshakes, so the block back-pressures its producer while a line is in flight and stalls cleanly on a busy UART transmitter.

---
 rtl/debug_hex_streamer.sv | 89 ++++++++
 tb/tb_debug_hex_streamer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/debug_hex_streamer.sv
// debug_hex_streamer: captures an ASCII hex word and streams it MSB-first plus a line terminator.
// Define DEBUG_HEX_CRLF_EN to end each line with CR LF instead of LF alone.
module debug_hex_streamer #(
  parameter int NBR_OF_NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NBR_OF_NIBBLES*8-1:0] ascii,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy
);
  localparam int W  = NBR_OF_NIBBLES * 8;
  localparam int IW = NBR_OF_NIBBLES > 1 ? $clog2(NBR_OF_NIBBLES) : 1;
`ifdef DEBUG_HEX_CRLF_EN
  typedef enum logic [1:0] {IDLE, CHAR, CR, LF} state_t;
  localparam state_t     TERM_ST = CR;
  localparam logic [7:0] TERM    = 8'h0D;
`else
  typedef enum logic [1:0] {IDLE, CHAR, LF} state_t;
  localparam state_t     TERM_ST = LF;
  localparam logic [7:0] TERM    = 8'h0A;
`endif
  state_t          state, state_n;
  logic [W-1:0]    sreg, sreg_n;
  logic [IW-1:0]   idx, idx_n;
  logic [7:0]      data_n;
  logic            valid_n;
  logic            xfer;
  assign xfer     = tx_valid && tx_ready;
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  // sreg holds the not-yet-sent bytes left-aligned, so the next one is always the top byte
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    idx_n   = idx;
    data_n  = tx_data;
    valid_n = tx_valid;
    case (state)
      IDLE: if (in_valid) begin
        sreg_n  = ascii << 8;
        idx_n   = IW'(NBR_OF_NIBBLES - 1);
        data_n  = ascii[W-1 -: 8];
        valid_n = 1'b1;
        state_n = CHAR;
      end
      CHAR: if (xfer) begin
        if (idx != '0) begin
          idx_n  = idx - IW'(1);
          data_n = sreg[W-1 -: 8];
          sreg_n = sreg << 8;
        end else begin
          data_n  = TERM;
          state_n = TERM_ST;
        end
      end
`ifdef DEBUG_HEX_CRLF_EN
      CR: if (xfer) begin
        data_n  = 8'h0A;
        state_n = LF;
      end
`endif
      LF: if (xfer) begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      sreg     <= '0;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      sreg     <= sreg_n;
      idx      <= idx_n;
      tx_data  <= data_n;
      tx_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_debug_hex_streamer.sv
// tb_debug_hex_streamer: randomized self-checking bench for debug_hex_streamer (4-nibble and 1-nibble instances).
module tb_debug_hex_streamer;
  localparam int N = 4;
`ifdef DEBUG_HEX_CRLF_EN
  localparam int TL = 2;
`else
  localparam int TL = 1;
`endif
  localparam int L = N + TL;
  typedef logic [7:0] bq_t[$];

  logic           clk = 0;
  logic           reset_n;
  logic [N*8-1:0] ascii;
  logic           in_valid, in_ready, tx_valid, tx_ready, busy;
  logic [7:0]     tx_data;
  logic [7:0]     ascii1;
  logic           in_valid1, in_ready1, tx_valid1, tx_ready1, busy1;
  logic [7:0]     tx_data1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  debug_hex_streamer #(.NBR_OF_NIBBLES(N)) dut (
    .clk(clk), .reset_n(reset_n), .ascii(ascii), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy));

  debug_hex_streamer #(.NBR_OF_NIBBLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ascii(ascii1), .in_valid(in_valid1), .in_ready(in_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .busy(busy1));

  // Expected line: characters MSB first, then the terminator
  function automatic bq_t line_of(input logic [N*8-1:0] w);
    bq_t q;
    q = {};
    for (int i = N - 1; i >= 0; i--) q.push_back(w[i*8 +: 8]);
    if (TL == 2) q.push_back(8'h0D);
    q.push_back(8'h0A);
    return q;
  endfunction

  task automatic test_reset();
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp [6];
    exp = '{8'h31, 8'h41, 8'h32, 8'h42, (TL == 2) ? 8'h0D : 8'h0A, 8'h0A};
    tx_ready = 1; ascii = 32'h31413242; in_valid = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    for (int j = 0; j < L; j++) begin
      #1;
      total++; if (tx_valid !== 1'b1 || tx_data !== exp[j]) begin bad++; $display("FAIL basic_byte%0d got=%b/%h exp=1/%h", j, tx_valid, tx_data, exp[j]); end
      total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_busy%0d got in_ready=%b busy=%b exp 0/1", j, in_ready, busy); end
      @(negedge clk);
    end
    #1;
    total++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_end got valid=%b in_ready=%b exp 0/1", tx_valid, in_ready); end
    @(negedge clk);
  endtask

  task automatic test_backpressure(input int words);
    for (int n = 0; n < words; n++) begin
      bq_t q;
      logic [N*8-1:0] w;
      logic [7:0] prev;
      bit stall;
      int cyc;
      w = (n == 0) ? 32'h31413242 : $urandom;
      q = line_of(w);
      ascii = w; in_valid = 1; tx_ready = $urandom_range(0, 1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle_ready word=%0d got=%b exp=1", n, in_ready); end
      @(negedge clk);
      in_valid = 0; ascii = $urandom;
      stall = 0; prev = 8'h00; cyc = 0;
      while (q.size() > 0 && cyc < 200) begin
        tx_ready = (n == 0) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
        #1;
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_drop word=%0d got=%b exp=1", n, tx_valid); end
        if (stall) begin
          total++; if (tx_data !== prev) begin bad++; $display("FAIL bp_stable word=%0d got=%h exp=%h", n, tx_data, prev); end
        end
        if (tx_valid && tx_ready) begin
          total++; if (tx_data !== q[0]) begin bad++; $display("FAIL bp_order word=%0d got=%h exp=%h", n, tx_data, q[0]); end
          void'(q.pop_front());
        end
        stall = tx_valid && !tx_ready;
        prev = tx_data;
        @(negedge clk);
        cyc++;
      end
      total++; if (cyc >= 200) begin bad++; $display("FAIL bp_timeout word=%0d got=%0d cycles exp<200", n, cyc); end
      #1;
      total++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_end word=%0d got valid=%b in_ready=%b exp 0/1", n, tx_valid, in_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bq_t q1, q2;
    q1 = line_of(32'h31413242);
    q2 = line_of(32'h46463030);
    tx_ready = 1; ascii = 32'h31413242; in_valid = 1;
    @(negedge clk);
    ascii = 32'h46463030;
    for (int j = 0; j < L; j++) begin
      #1;
      total++; if (tx_valid !== 1'b1 || tx_data !== q1[j]) begin bad++; $display("FAIL hold_first%0d got=%b/%h exp=1/%h", j, tx_valid, tx_data, q1[j]); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready%0d got=%b exp=0", j, in_ready); end
      @(negedge clk);
    end
    #1;
    total++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_idle got valid=%b in_ready=%b exp 0/1", tx_valid, in_ready); end
    @(negedge clk);
    in_valid = 0; ascii = $urandom;
    for (int j = 0; j < L; j++) begin
      #1;
      total++; if (tx_valid !== 1'b1 || tx_data !== q2[j]) begin bad++; $display("FAIL hold_second%0d got=%b/%h exp=1/%h", j, tx_valid, tx_data, q2[j]); end
      @(negedge clk);
    end
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_end got=%b exp=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    tx_ready = 1; ascii = $urandom; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1;
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0/00", tx_valid, tx_data); end
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
    @(negedge clk);
    reset_n = 1;
    for (int j = 0; j < L + 2; j++) begin
      #1;
      total++; if (tx_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_stale%0d got valid=%b in_ready=%b exp 0/1", j, tx_valid, in_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_min_width();
    logic [7:0] exp [3];
    exp = '{8'h30, (TL == 2) ? 8'h0D : 8'h0A, 8'h0A};
    tx_ready1 = 1; ascii1 = 8'h30; in_valid1 = 1;
    @(negedge clk);
    in_valid1 = 0; ascii1 = 8'h5A;
    for (int j = 0; j < 1 + TL; j++) begin
      #1;
      total++; if (tx_valid1 !== 1'b1 || tx_data1 !== exp[j]) begin bad++; $display("FAIL min_byte%0d got=%b/%h exp=1/%h", j, tx_valid1, tx_data1, exp[j]); end
      @(negedge clk);
    end
    #1;
    total++; if (tx_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin bad++; $display("FAIL min_end got valid=%b in_ready=%b exp 0/1", tx_valid1, in_ready1); end
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; ascii = '0; in_valid = 0; tx_ready = 0;
    ascii1 = '0; in_valid1 = 0; tx_ready1 = 0;
    test_reset();
    test_basic();
    test_backpressure(8);
    test_back_to_back();
    test_reset_mid();
    test_min_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
